// File: rtl/cdb_data_controller_pkg.sv
// Shared CPU parameters for the common data bus (CDB) result path.
package cdb_data_controller_pkg;

  localparam int WORD_SIZE  = 32;  // data/address word width
  localparam int RB_SIZE    = 8;   // reorder-buffer entries, one CDB lane each
  localparam int RB_INDEX   = 3;   // reorder-buffer index width
  localparam int FU_NUM     = 4;   // ALU + store functional units
  localparam int STORER_NUM = 1;   // store FUs occupy the top FU indices
  localparam int RB_NULL    = 0;   // reserved "no entry" reorder-buffer index

endpackage

// File: rtl/cdb_lane_select.sv
// Per-lane priority select: picks the lowest-index valid FU targeting this
// reorder-buffer lane and forwards its data and (store-only) address.
module cdb_lane_select #(
  parameter int WORD_SIZE  = 32,
  parameter int RB_INDEX   = 3,
  parameter int FU_NUM     = 4,
  parameter int STORER_NUM = 1,
  parameter int LANE       = 0
) (
  input  logic [FU_NUM*WORD_SIZE-1:0]     data_bus,
  input  logic [FU_NUM-1:0]               valid_bus,
  input  logic [STORER_NUM*WORD_SIZE-1:0] addr_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]      RB_index_bus,
  output logic [WORD_SIZE-1:0]            sel_data,
  output logic [WORD_SIZE-1:0]            sel_addr,
  output logic                            sel_hit
);
  import cdb_data_controller_pkg::*;

  localparam int ST_BASE = FU_NUM - STORER_NUM;
  localparam logic [RB_INDEX-1:0] LANE_ID = RB_INDEX'(LANE);
  // The NULL entry never gets a lane result.
  localparam bit LANE_LIVE = (LANE != RB_NULL);

  // Address each FU would put on the bus: store FUs carry their address slice,
  // ALU FUs always contribute zero.
  logic [FU_NUM-1:0][WORD_SIZE-1:0] fu_addr;

  genvar f;
  generate
    for (f = 0; f < FU_NUM; f++) begin : g_fu_addr
      if (f >= ST_BASE) begin : g_st
        assign fu_addr[f] = addr_bus[(f-ST_BASE)*WORD_SIZE +: WORD_SIZE];
      end else begin : g_alu
        assign fu_addr[f] = '0;
      end
    end
  endgenerate

  // Scan high to low so the lowest matching FU index is the last to override.
  always_comb begin
    sel_hit  = 1'b0;
    sel_data = '0;
    sel_addr = '0;
    for (int i = FU_NUM-1; i >= 0; i--) begin
      if (LANE_LIVE && valid_bus[i] &&
          RB_index_bus[i*RB_INDEX +: RB_INDEX] == LANE_ID) begin
        sel_hit  = 1'b1;
        sel_data = data_bus[i*WORD_SIZE +: WORD_SIZE];
        sel_addr = fu_addr[i];
      end
    end
  end

endmodule

// File: rtl/cdb_data_controller.sv
// CDB data controller: routes FU results onto per-reorder-buffer-entry lanes,
// registered with one cycle of latency. Valid pulses for one cycle per capture;
// data/addr hold until the next capture on that lane.
module cdb_data_controller #(
  parameter int WORD_SIZE  = cdb_data_controller_pkg::WORD_SIZE,
  parameter int RB_SIZE    = cdb_data_controller_pkg::RB_SIZE,
  parameter int RB_INDEX   = cdb_data_controller_pkg::RB_INDEX,
  parameter int FU_NUM     = cdb_data_controller_pkg::FU_NUM,
  parameter int STORER_NUM = cdb_data_controller_pkg::STORER_NUM
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [FU_NUM*WORD_SIZE-1:0]     data_bus,
  input  logic [FU_NUM-1:0]               valid_bus,
  input  logic [STORER_NUM*WORD_SIZE-1:0] addr_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]      RB_index_bus,
  output logic [RB_SIZE*WORD_SIZE-1:0]    CDB_data_data,
  output logic [RB_SIZE-1:0]              CDB_data_valid,
  output logic [RB_SIZE*WORD_SIZE-1:0]    CDB_data_addr
);
  import cdb_data_controller_pkg::*;

  logic [RB_SIZE-1:0][WORD_SIZE-1:0] lane_data, lane_addr;
  logic [RB_SIZE-1:0]                lane_hit;

  logic [RB_SIZE-1:0][WORD_SIZE-1:0] data_q, data_d;
  logic [RB_SIZE-1:0][WORD_SIZE-1:0] addr_q, addr_d;
  logic [RB_SIZE-1:0]                valid_q, valid_d;

  // One selector per lane; indices >= RB_SIZE match no lane and drop out.
  genvar e;
  generate
    for (e = 0; e < RB_SIZE; e++) begin : g_lane
      cdb_lane_select #(
        .WORD_SIZE  (WORD_SIZE),
        .RB_INDEX   (RB_INDEX),
        .FU_NUM     (FU_NUM),
        .STORER_NUM (STORER_NUM),
        .LANE       (e)
      ) u_sel (
        .data_bus     (data_bus),
        .valid_bus    (valid_bus),
        .addr_bus     (addr_bus),
        .RB_index_bus (RB_index_bus),
        .sel_data     (lane_data[e]),
        .sel_addr     (lane_addr[e]),
        .sel_hit      (lane_hit[e])
      );
    end
  endgenerate

  // Next-state: captured lanes take the winner, others hold data/addr.
  always_comb begin
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = lane_hit;
    for (int i = 0; i < RB_SIZE; i++) begin
      if (lane_hit[i]) begin
        data_d[i] = lane_data[i];
        addr_d[i] = lane_addr[i];
      end
    end
  end

  // Output registers, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign CDB_data_data  = data_q;
  assign CDB_data_addr  = addr_q;
  assign CDB_data_valid = valid_q;

endmodule

// File: tb/tb_cdb_data_controller.sv
// Directed bench for cdb_data_controller: vector table plus reset/hold sequences.
module tb_cdb_data_controller;

  localparam int W  = 32;
  localparam int RB = 8;
  localparam int RI = 3;
  localparam int FU = 4;
  localparam int ST = 1;

  logic               clk;
  logic               reset;
  logic [FU*W-1:0]    data_bus;
  logic [FU-1:0]      valid_bus;
  logic [ST*W-1:0]    addr_bus;
  logic [FU*RI-1:0]   RB_index_bus;
  logic [RB*W-1:0]    CDB_data_data;
  logic [RB-1:0]      CDB_data_valid;
  logic [RB*W-1:0]    CDB_data_addr;

  cdb_data_controller dut (
    .clk            (clk),
    .reset          (reset),
    .data_bus       (data_bus),
    .valid_bus      (valid_bus),
    .addr_bus       (addr_bus),
    .RB_index_bus   (RB_index_bus),
    .CDB_data_data  (CDB_data_data),
    .CDB_data_valid (CDB_data_valid),
    .CDB_data_addr  (CDB_data_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   vld;
    logic [11:0]  idx;   // {FU3,FU2,FU1,FU0}
    logic [127:0] dat;   // {FU3,FU2,FU1,FU0}
    logic [31:0]  adr;   // store FU3 address
    logic [7:0]   ev;    // expected valid vector
    int           lane;  // lane whose data/addr is checked
    logic [31:0]  ed;
    logic [31:0]  ea;
  } vec_t;

  vec_t v[11];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] vld, input logic [11:0] idx,
                       input logic [127:0] dat, input logic [31:0] adr);
    valid_bus    = vld;
    RB_index_bus = idx;
    data_bus     = dat;
    addr_bus     = adr;
  endtask

  function automatic logic [31:0] lane_d(input int e);
    return CDB_data_data[e*W +: W];
  endfunction

  function automatic logic [31:0] lane_a(input int e);
    return CDB_data_addr[e*W +: W];
  endfunction

  initial begin
    // vld, idx{3,2,1,0}, dat{3,2,1,0}, addr, exp valid, lane, exp data, exp addr
    v[0]  = '{4'b0001, {3'd0,3'd0,3'd0,3'd1}, {32'd0,32'd0,32'd0,32'd5},   32'd0,   8'h02, 1, 32'd5,   32'd0};
    v[1]  = '{4'b0000, {3'd0,3'd0,3'd1,3'd0}, {32'd0,32'd0,32'd99,32'd0},  32'd0,   8'h00, 1, 32'd5,   32'd0};
    v[2]  = '{4'b1000, {3'd2,3'd0,3'd0,3'd0}, {32'd7,32'd0,32'd0,32'd0},   32'd100, 8'h04, 2, 32'd7,   32'd100};
    v[3]  = '{4'b0011, {3'd0,3'd0,3'd1,3'd1}, {32'd0,32'd0,32'd9,32'd3},   32'd0,   8'h02, 1, 32'd3,   32'd0};
    v[4]  = '{4'b0011, {3'd0,3'd0,3'd2,3'd1}, {32'd0,32'd0,32'd22,32'd11}, 32'd0,   8'h06, 2, 32'd22,  32'd0};
    v[5]  = '{4'b0001, {3'd0,3'd0,3'd0,3'd0}, {32'd0,32'd0,32'd0,32'd4},   32'd0,   8'h00, 0, 32'd0,   32'd0};
    v[6]  = '{4'b1100, {3'd3,3'd3,3'd0,3'd0}, {32'd44,32'd33,32'd0,32'd0}, 32'd55,  8'h08, 3, 32'd33,  32'd0};
    v[7]  = '{4'b1000, {3'd3,3'd0,3'd0,3'd0}, {32'd44,32'd0,32'd0,32'd0},  32'd55,  8'h08, 3, 32'd44,  32'd55};
    v[8]  = '{4'b0010, {3'd0,3'd0,3'd7,3'd0}, {32'd0,32'd0,32'h77,32'd0},  32'd0,   8'h80, 7, 32'h77,  32'd0};
    v[9]  = '{4'b1111, {3'd7,3'd6,3'd5,3'd4}, {32'd4,32'd3,32'd2,32'd1},   32'd9,   8'hF0, 7, 32'd4,   32'd9};
    v[10] = '{4'b0000, {3'd0,3'd0,3'd0,3'd0}, 128'd0,                      32'd0,   8'h00, 4, 32'd1,   32'd0};

    reset = 1'b0;
    drive(4'b0, 12'b0, 128'b0, 32'b0);
    step();
    step();
    check("reset_valid", {24'b0, CDB_data_valid}, 32'd0);
    check("reset_data_any", {31'b0, |CDB_data_data}, 32'd0);
    check("reset_addr_any", {31'b0, |CDB_data_addr}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(v[i].vld, v[i].idx, v[i].dat, v[i].adr);
      step();
      check($sformatf("v%0d_valid", i), {24'b0, CDB_data_valid}, {24'b0, v[i].ev});
      check($sformatf("v%0d_data", i), lane_d(v[i].lane), v[i].ed);
      check($sformatf("v%0d_addr", i), lane_a(v[i].lane), v[i].ea);
    end

    // Held valid: three cycles in, three valid cycles out, then drop.
    for (int c = 0; c < 3; c++) begin
      drive(4'b0100, {3'd0,3'd5,3'd0,3'd0}, {32'd0,32'h55 + 32'(c),32'd0,32'd0}, 32'd0);
      step();
      check($sformatf("hold%0d_valid", c), {24'b0, CDB_data_valid}, 32'h20);
      check($sformatf("hold%0d_data", c), lane_d(5), 32'h55 + 32'(c));
    end
    drive(4'b0, 12'b0, 128'b0, 32'b0);
    step();
    check("hold_end_valid", {24'b0, CDB_data_valid}, 32'd0);
    check("hold_end_data", lane_d(5), 32'h57);

    // Capture, then reset mid-cycle: outputs clear without a clock edge.
    drive(4'b0001, {3'd0,3'd0,3'd0,3'd6}, {32'd0,32'd0,32'd0,32'hAB}, 32'd0);
    step();
    check("pre_rst_valid", {24'b0, CDB_data_valid}, 32'h40);
    check("pre_rst_data", lane_d(6), 32'hAB);
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", {24'b0, CDB_data_valid}, 32'd0);
    check("async_rst_data_any", {31'b0, |CDB_data_data}, 32'd0);
    check("async_rst_addr_any", {31'b0, |CDB_data_addr}, 32'd0);
    // Capture still presented across an edge in reset is discarded.
    step();
    check("rst_edge_valid", {24'b0, CDB_data_valid}, 32'd0);
    check("rst_edge_data_any", {31'b0, |CDB_data_data}, 32'd0);

    // Release with no valids: everything stays zero.
    drive(4'b0, 12'b0, 128'b0, 32'b0);
    reset = 1'b1;
    step();
    check("post_rst_valid", {24'b0, CDB_data_valid}, 32'd0);
    check("post_rst_data_any", {31'b0, |CDB_data_data}, 32'd0);

    // First capture after release lands on the next edge.
    drive(4'b1000, {3'd6,3'd0,3'd0,3'd0}, {32'hCD,32'd0,32'd0,32'd0}, 32'd300);
    step();
    check("first_cap_valid", {24'b0, CDB_data_valid}, 32'h40);
    check("first_cap_data", lane_d(6), 32'hCD);
    check("first_cap_addr", lane_a(6), 32'd300);
    drive(4'b0, 12'b0, 128'b0, 32'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_data_controller.md
CDB_DATA_CONTROLLER -- requirements
Module: cdb_data_controller

Interface
REQ-001 Parameter WORD_SIZE, 32, data/address word width.
REQ-002 Parameter RB_SIZE, 8, number of reorder-buffer entries; one CDB lane per entry.
REQ-003 Parameter RB_INDEX, 3, width of a reorder-buffer index (clog2 RB_SIZE).
REQ-004 Parameter FU_NUM, 4, total functional units (ALU and store).
REQ-005 Parameter STORER_NUM, 1, number of store FUs; these are FU indices FU_NUM-STORER_NUM .. FU_NUM-1.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 data_bus  input  FU_NUM*WORD_SIZE  result word of FU f in slice f.
REQ-009 valid_bus  input  FU_NUM  bit f high = FU f presents a result this cycle.
REQ-010 addr_bus  input  STORER_NUM*WORD_SIZE  store address of store FU i in slice i (FU index FU_NUM-STORER_NUM+i).
REQ-011 RB_index_bus  input  FU_NUM*RB_INDEX  target reorder-buffer entry of FU f in slice f.
REQ-012 CDB_data_data  output  RB_SIZE*WORD_SIZE  lane e = result for reorder-buffer entry e.
REQ-013 CDB_data_valid  output  RB_SIZE  bit e high = lane e carries a new result.
REQ-014 CDB_data_addr  output  RB_SIZE*WORD_SIZE  lane e = store address for entry e.

Function
REQ-015 At each rising clk edge, for every FU f with valid_bus[f]=1, lane e=RB_index_bus[f] SHALL capture data_bus slice f; outputs are registered, latency exactly 1 cycle.
REQ-016 Lane e captured from a store FU SHALL set its addr lane to that FU's addr_bus slice; captured from an ALU FU SHALL set addr lane to 0.
REQ-017 CDB_data_valid[e] SHALL be 1 for exactly the cycle following a capture and 0 in any cycle following an edge with no writer for lane e.
REQ-018 Lanes without a writer SHALL hold their previous data and addr values.
REQ-019 Reorder-buffer index 0 is reserved (NULL); an FU presenting RB_index 0 SHALL be ignored and lane 0 SHALL remain invalid.
REQ-020 If two or more valid FUs target the same entry in one cycle, the lowest FU index SHALL win; others are dropped without indication.
REQ-021 Different FUs targeting different entries in the same cycle SHALL all be captured in that cycle.
REQ-022 An FU holding valid for N consecutive cycles SHALL produce N consecutive valid cycles on its lane; no handshake back to FUs exists.
REQ-023 RB_index values >= RB_SIZE SHALL be ignored.

Reset
REQ-024 While reset=0, all CDB_data_data, CDB_data_valid and CDB_data_addr bits SHALL be 0 immediately, independent of clk.
REQ-025 A capture pending at reset assertion SHALL be discarded; first capture occurs at the first rising edge with reset=1.

Structure
REQ-026 WORD_SIZE, RB_SIZE, RB_INDEX, FU_NUM, STORER_NUM and the NULL index constant (0) SHALL live in the shared CPU parameter package.
REQ-027 One sub-module, cdb_lane_select, SHALL implement the per-lane priority select (FU_NUM requests -> winner data/addr/hit), instantiated RB_SIZE times.

Verification
REQ-028 ALU FU0 valid, RB_index=1, data=5 for one cycle -> next cycle lane1 valid=1, data=5, addr=0; following cycle valid=0, data still 5.
REQ-029 Store FU3 valid, RB_index=2, data=7, addr=100 -> next cycle lane2 valid=1, data=7, addr=100.
REQ-030 FU0 (idx1,data=3) and FU1 (idx1,data=9) same cycle -> lane1 data=3; FU0 (idx1) and FU1 (idx2) -> both lanes valid next cycle.
REQ-031 FU0 valid with RB_index=0, data=4 -> all lanes remain valid=0.
REQ-032 Drive a capture, assert reset=0 mid-cycle -> all outputs 0 immediately; release reset with no valids -> outputs stay 0.
